// File: rtl/apb_slave_responder29.sv
// APB completer with a word-addressed register file, fixed wait-state insertion,
// PSLVERR on bad accesses, a level interrupt from the last register and a sticky protocol-error flag.
module apb_slave_responder29 #(
  parameter int unsigned PADDR_WIDTH29  = 32,
  parameter int unsigned PWDATA_WIDTH29 = 32,
  parameter int unsigned PRDATA_WIDTH29 = 32,
  parameter int unsigned PSEL_INDEX     = 0,
  parameter logic [31:0] BASE_ADDR      = 32'h0,
  parameter int unsigned NUM_REGS       = 16,
  parameter int unsigned WAIT_STATES    = 1,
  parameter logic [31:0] ID_VALUE       = 32'hA9B0_0029
) (
  input  logic                      pclock29,
  input  logic                      preset29,
  input  logic [PADDR_WIDTH29-1:0]  paddr29,
  input  logic                      prwd29,
  input  logic [PWDATA_WIDTH29-1:0] pwdata29,
  input  logic [15:0]               psel29,
  input  logic                      penable29,
  output logic [PRDATA_WIDTH29-1:0] prdata29,
  output logic                      pready29,
  output logic                      pslverr29,
  output logic                      ua_int29,
  output logic                      prot_err
);

  localparam int unsigned IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [PADDR_WIDTH29-1:0]  BASE = PADDR_WIDTH29'(BASE_ADDR);
  localparam logic [PRDATA_WIDTH29-1:0] ID   = PRDATA_WIDTH29'(ID_VALUE);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  logic [1:0]                state_q, state_d;
  logic [3:0]                wcnt_q, wcnt_d;
  logic [PADDR_WIDTH29-1:0]  addr_q, addr_d;
  logic                      write_q, write_d;
  logic [PWDATA_WIDTH29-1:0] wdata_q, wdata_d;
  logic [PRDATA_WIDTH29-1:0] prdata_q, prdata_d;
  logic                      pready_q, pready_d;
  logic                      pslverr_q, pslverr_d;
  logic                      ua_int_q, ua_int_d;
  logic                      prot_err_q, prot_err_d;
  logic [PWDATA_WIDTH29-1:0] regs_q [NUM_REGS];
  logic [PWDATA_WIDTH29-1:0] regs_d [NUM_REGS];

  logic                      sel;
  logic [PADDR_WIDTH29-1:0]  off;
  logic [IW-1:0]             idx;
  logic                      acc_err;
  logic [PRDATA_WIDTH29-1:0] rd_data;
  logic [PRDATA_WIDTH29-1:0] resp_data;
  logic                      unused_psel;

  assign sel         = psel29[PSEL_INDEX];
  assign unused_psel = ^psel29;

  // Decode runs on the latched address so the response is stable through the wait states.
  always_comb begin
    off     = addr_q - BASE;
    idx     = off[IW+1:2];
    acc_err = (addr_q < BASE) || (off[1:0] != 2'b00) ||
              ((off >> 2) >= PADDR_WIDTH29'(NUM_REGS)) ||
              (write_q && ((off >> 2) == '0));
    rd_data   = (idx == '0) ? ID : regs_q[idx];
    resp_data = (acc_err || write_q) ? '0 : rd_data;
  end

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    addr_d     = addr_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    prdata_d   = '0;
    pready_d   = 1'b0;
    pslverr_d  = 1'b0;
    prot_err_d = prot_err_q;
    regs_d     = regs_q;

    case (state_q)
      ST_IDLE: begin
        if (sel && !penable29) begin
          state_d = ST_SETUP;
          addr_d  = paddr29;
          write_d = prwd29;
          wdata_d = pwdata29;
          wcnt_d  = 4'(WAIT_STATES);
        end else if (sel && penable29) begin
          prot_err_d = 1'b1;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
        if (wcnt_q == '0) begin
          pready_d  = 1'b1;
          pslverr_d = acc_err;
          prdata_d  = resp_data;
        end
      end
      ST_ACCESS: begin
        if (pready_q) begin
          state_d = ST_IDLE;
          if (write_q && !acc_err) regs_d[idx] = wdata_q;
        end else if (!sel || !penable29 || (paddr29 != addr_q) || (prwd29 != write_q)) begin
          prot_err_d = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
          if (wcnt_q == 4'd1) begin
            pready_d  = 1'b1;
            pslverr_d = acc_err;
            prdata_d  = resp_data;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Taken from the next-state array so the interrupt tracks a write in the cycle right after it commits.
    ua_int_d = |regs_d[NUM_REGS-1];
  end

  always_ff @(posedge pclock29) begin
    if (preset29) begin
      state_q    <= ST_IDLE;
      wcnt_q     <= '0;
      addr_q     <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      prdata_q   <= '0;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
      ua_int_q   <= 1'b0;
      prot_err_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      addr_q     <= addr_d;
      write_q    <= write_d;
      wdata_q    <= wdata_d;
      prdata_q   <= prdata_d;
      pready_q   <= pready_d;
      pslverr_q  <= pslverr_d;
      ua_int_q   <= ua_int_d;
      prot_err_q <= prot_err_d;
      regs_q     <= regs_d;
    end
  end

  assign prdata29  = prdata_q;
  assign pready29  = pready_q;
  assign pslverr29 = pslverr_q;
  assign ua_int29  = ua_int_q;
  assign prot_err  = prot_err_q;

endmodule

// File: tb/tb_apb_slave_responder29.sv
// Bench for apb_slave_responder29: two instances (1 wait state at a non-zero base, 0 wait states at base 0)
// share one APB bus, checked against a register-file model driven by directed and random transfers.
module tb_apb_slave_responder29;

  localparam int unsigned NREG   = 16;
  localparam logic [31:0] ID     = 32'hA9B0_0029;
  localparam logic [31:0] BASE_A = 32'h0000_0100;
  localparam logic [31:0] BASE_B = 32'h0000_0000;
  localparam int unsigned IDX_A  = 2;
  localparam int unsigned IDX_B  = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] paddr, pwdata;
  logic        prwd, penable;
  logic [15:0] psel;
  logic [31:0] prdata_a, prdata_b;
  logic        pready_a, pready_b, pslverr_a, pslverr_b, ua_a, ua_b, perr_a, perr_b;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  apb_slave_responder29 #(
    .PSEL_INDEX(IDX_A), .BASE_ADDR(BASE_A), .NUM_REGS(NREG), .WAIT_STATES(1), .ID_VALUE(ID)
  ) u_dut_a (
    .pclock29(clk), .preset29(rst), .paddr29(paddr), .prwd29(prwd), .pwdata29(pwdata),
    .psel29(psel), .penable29(penable), .prdata29(prdata_a), .pready29(pready_a),
    .pslverr29(pslverr_a), .ua_int29(ua_a), .prot_err(perr_a)
  );

  apb_slave_responder29 #(
    .PSEL_INDEX(IDX_B), .BASE_ADDR(BASE_B), .NUM_REGS(NREG), .WAIT_STATES(0), .ID_VALUE(ID)
  ) u_dut_b (
    .pclock29(clk), .preset29(rst), .paddr29(paddr), .prwd29(prwd), .pwdata29(pwdata),
    .psel29(psel), .penable29(penable), .prdata29(prdata_b), .pready29(pready_b),
    .pslverr29(pslverr_b), .ua_int29(ua_b), .prot_err(perr_b)
  );

  int          tgt = 0;
  logic [31:0] o_rd;
  logic        o_rdy, o_err, o_ua, o_pe;
  always_comb begin
    o_rd  = (tgt == 0) ? prdata_a  : prdata_b;
    o_rdy = (tgt == 0) ? pready_a  : pready_b;
    o_err = (tgt == 0) ? pslverr_a : pslverr_b;
    o_ua  = (tgt == 0) ? ua_a      : ua_b;
    o_pe  = (tgt == 0) ? perr_a    : perr_b;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: plain register array per instance, plus the sticky error bit.
  logic [31:0] mdl [2][NREG];
  logic        mdl_prot [2];
  int          last_rdy_cyc = 0;

  function automatic logic [31:0] base_of(input int t);
    return (t == 0) ? BASE_A : BASE_B;
  endfunction

  function automatic int ws_of(input int t);
    return (t == 0) ? 1 : 0;
  endfunction

  function automatic logic [15:0] psel_of(input int t);
    logic [15:0] v;
    v = '0;
    v[(t == 0) ? IDX_A : IDX_B] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    for (int t = 0; t < 2; t++) begin
      for (int r = 0; r < NREG; r++) mdl[t][r] = '0;
      mdl_prot[t] = 1'b0;
    end
  endtask

  task automatic model_xfer(input int t, input logic [31:0] a, input logic w, input logic [31:0] d,
                            output logic err, output logic [31:0] rd);
    longint unsigned off, word;
    err = 1'b0;
    rd  = '0;
    if (a < base_of(t)) err = 1'b1;
    else begin
      off  = longint'(a) - longint'(base_of(t));
      word = off / 4;
      if ((off % 4) != 0 || word >= NREG || (w && word == 0)) err = 1'b1;
      else if (w) mdl[t][word] = d;
      else rd = (word == 0) ? ID : mdl[t][word];
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_rdy"},  32'(o_rdy), 32'd0);
    check_eq({tag, "_err"},  32'(o_err), 32'd0);
    check_eq({tag, "_rd"},   o_rd, 32'd0);
    check_eq({tag, "_ua"},   32'(o_ua), 32'(mdl[tgt][NREG-1] != 0));
    check_eq({tag, "_prot"}, 32'(o_pe), 32'(mdl_prot[tgt]));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_idle("idle");
      psel    = '0;
      penable = 1'b0;
    end
  endtask

  task automatic xfer(input int t, input logic [31:0] a, input logic w, input logic [31:0] d);
    int          k;
    logic        err_e;
    logic [31:0] rd_e;
    @(negedge clk);
    check_idle("pre");
    tgt     = t;
    psel    = psel_of(t);
    penable = 1'b0;
    paddr   = a;
    prwd    = w;
    pwdata  = d;
    @(negedge clk);
    penable = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!o_rdy && k < 20);
    check_eq("latency", 32'(k), 32'(ws_of(t) + 1));
    if (o_rdy) begin
      model_xfer(t, a, w, d, err_e, rd_e);
      check_eq("pslverr", 32'(o_err), 32'(err_e));
      check_eq("prdata", o_rd, rd_e);
      last_rdy_cyc = cyc;
    end
  endtask

  initial begin
    int          c1;
    logic [31:0] a, b, d;
    logic        w;
    int          t, r;

    rst = 1'b1; psel = '0; penable = 1'b0; paddr = '0; prwd = 1'b0; pwdata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tgt = 0; check_idle("rst_a");
    tgt = 1; check_idle("rst_b");

    // Basic write/read, ID register, decode errors on instance A (1 wait state).
    xfer(0, BASE_A + 4, 1'b1, 32'hDEAD_BEEF);
    xfer(0, BASE_A + 4, 1'b0, '0);
    xfer(0, BASE_A + 0, 1'b0, '0);
    xfer(0, BASE_A + 0, 1'b1, 32'h1234_5678);
    xfer(0, BASE_A + 0, 1'b0, '0);
    xfer(0, BASE_A + 2, 1'b0, '0);
    xfer(0, BASE_A + 2, 1'b1, 32'hFFFF_FFFF);
    xfer(0, BASE_A + 64, 1'b1, 32'hFFFF_FFFF);
    xfer(0, BASE_A + 64, 1'b0, '0);
    xfer(0, BASE_A - 4, 1'b0, '0);
    xfer(0, BASE_A + 4, 1'b0, '0);
    xfer(0, BASE_A + 60, 1'b1, 32'h1);
    xfer(0, BASE_A + 60, 1'b1, 32'h0);
    xfer(0, BASE_A + 60, 1'b1, 32'h8000_0000);
    idle(1);

    // Drop psel during the wait state of a write to reg 2.
    @(negedge clk);
    check_idle("ab_pre");
    tgt = 0; psel = psel_of(0); penable = 1'b0; paddr = BASE_A + 8; prwd = 1'b1; pwdata = 32'hCAFE_F00D;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    check_eq("ab_wait_rdy", 32'(o_rdy), 32'd0);
    psel = '0;
    @(negedge clk);
    mdl_prot[0] = 1'b1;
    check_eq("ab_rdy", 32'(o_rdy), 32'd0);
    check_eq("ab_prot", 32'(o_pe), 32'd1);
    penable = 1'b0;
    idle(3);
    xfer(0, BASE_A + 8, 1'b0, '0);
    idle(1);

    // Reset in the middle of a write access.
    @(negedge clk);
    check_idle("rs_pre");
    tgt = 0; psel = psel_of(0); penable = 1'b0; paddr = BASE_A + 12; prwd = 1'b1; pwdata = 32'h5555_AAAA;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; psel = '0; penable = 1'b0;
    model_reset();
    check_idle("rs_post");
    check_eq("rs_prot_b", 32'(perr_b), 32'd0);
    xfer(0, BASE_A + 12, 1'b0, '0);
    xfer(0, BASE_A + 12, 1'b1, 32'h0BAD_F00D);
    xfer(0, BASE_A + 12, 1'b0, '0);
    xfer(0, BASE_A + 60, 1'b0, '0);

    // Instance B (no wait states): back-to-back reads, then an access without setup.
    xfer(1, BASE_B + 4, 1'b1, $urandom);
    xfer(1, BASE_B + 8, 1'b1, $urandom);
    xfer(1, BASE_B + 4, 1'b0, '0);
    c1 = last_rdy_cyc;
    xfer(1, BASE_B + 8, 1'b0, '0);
    check_eq("b2b_gap", 32'(last_rdy_cyc - c1), 32'd3);
    idle(1);
    @(negedge clk);
    tgt = 1; psel = psel_of(1); penable = 1'b1; paddr = BASE_B + 4; prwd = 1'b0;
    @(negedge clk);
    mdl_prot[1] = 1'b1;
    check_eq("nosetup_prot", 32'(o_pe), 32'd1);
    check_eq("nosetup_rdy", 32'(o_rdy), 32'd0);
    psel = '0; penable = 1'b0;
    xfer(1, BASE_B + 0, 1'b0, '0);

    // Random transfers across both instances.
    for (int n = 0; n < 200; n++) begin
      t = int'($urandom_range(0, 1));
      b = base_of(t);
      r = int'($urandom_range(0, NREG - 1));
      case ($urandom_range(0, 5))
        0, 1, 2: a = b + 32'(4 * r);
        3:       a = b + 32'(4 * r) + $urandom_range(1, 3);
        4:       a = b + 32'(4 * (NREG + $urandom_range(0, 7)));
        default: a = (b >= 32) ? b - 32'(4 * $urandom_range(1, 8)) : b;
      endcase
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      if (a == b + 32'(4 * (NREG - 1)) && $urandom_range(0, 1) == 1) d = 32'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
      xfer(t, a, w, d);
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
